// File: rtl/posit_mult_if.sv
// posit_mult_if: operand/result handshake bundle between posit_mult_core and its neighbours.
interface posit_mult_if #(
    parameter int N  = 32,
    parameter int ES = 2,
    parameter int RS = $clog2(N)
) ();
    logic                   in_valid, in_ready;
    logic [N-1:0]           IN1, IN2;
    logic                   Sign1, Sign2;
    logic signed [RS:0]     k1, k2;
    logic [ES-1:0]          Exp1, Exp2;
    logic [N-1:0]           Mant1, Mant2;
    logic                   zero1, zero2, inf1, inf2;
    logic                   out_valid, out_ready;
    logic [N-1:0]           IN1_o, IN2_o;
    logic [2*N-1:0]         Mult_Mant_N;
    logic signed [RS+ES+1:0] Total_EO, Total_EON;
    logic [ES-1:0]          E_O;
    logic signed [RS+2:0]   sumR, R_O;
    logic                   Sign, inf, zero;
    modport master (
        output in_valid, IN1, IN2, Sign1, Sign2, k1, k2, Exp1, Exp2, Mant1, Mant2,
               zero1, zero2, inf1, inf2, out_ready,
        input  in_ready, out_valid, IN1_o, IN2_o, Mult_Mant_N, Total_EO, Total_EON,
               E_O, sumR, R_O, Sign, inf, zero
    );
    modport slave (
        input  in_valid, IN1, IN2, Sign1, Sign2, k1, k2, Exp1, Exp2, Mant1, Mant2,
               zero1, zero2, inf1, inf2, out_ready,
        output in_ready, out_valid, IN1_o, IN2_o, Mult_Mant_N, Total_EO, Total_EON,
               E_O, sumR, R_O, Sign, inf, zero
    );
endinterface

// File: rtl/posit_mult_core.sv
// posit_mult_core: iterative posit mantissa multiply, normalise and scale combine.
// POSIT_MULT_RADIX4_EN selects the radix-4 engine; otherwise radix-2.
module posit_mult_core #(
    parameter int N  = 32,
    parameter int ES = 2,
    parameter int RS = $clog2(N)
) (
    input logic         clk,
    input logic         rst_n,
    posit_mult_if.slave bus
);
    localparam int EW = RS + ES + 2;
`ifdef POSIT_MULT_RADIX4_EN
    localparam int ITER = N / 2;
    localparam int SH = 2;
`else
    localparam int ITER = N;
    localparam int SH = 1;
`endif
    localparam int CW = $clog2(ITER + 1);
    typedef enum logic [1:0] {IDLE, MULT, NORM, DONE} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [2*N-1:0] acc, mc, step, mult_mant;
    logic [N-1:0] mp, in1_r, in2_r;
    logic signed [RS:0] k1_r, k2_r;
    logic [ES-1:0] e1_r, e2_r;
    logic s1, s2, z1, z2, f1, f2, special, special_in, ovf, sign_r, inf_r, zero_r;
    logic signed [EW-1:0] k1x, k2x, eo_nx, total_eo;
    logic signed [RS+2:0] sumr;
`ifdef POSIT_MULT_RADIX4_EN
    logic [2*N-1:0] mc3;
    assign step = mp[1:0] == 2'd0 ? '0 : mp[1:0] == 2'd1 ? mc : mp[1:0] == 2'd2 ? mc << 1 : mc3;
`else
    assign step = mp[0] ? mc : '0;
`endif
    assign special_in = bus.zero1 | bus.zero2 | bus.inf1 | bus.inf2;
    assign special    = z1 | z2 | f1 | f2;
    assign ovf        = acc[2*N-1];
    assign k1x        = {{(ES+1){k1_r[RS]}}, k1_r};
    assign k2x        = {{(ES+1){k2_r[RS]}}, k2_r};
    assign eo_nx      = (k1x <<< ES) + (k2x <<< ES) + EW'(e1_r) + EW'(e2_r) + EW'(ovf);
    assign sumr       = {total_eo[EW-1], total_eo[EW-1:ES]};
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    always_comb begin
        state_nx = state == IDLE ? (bus.in_valid ? (special_in ? NORM : MULT) : IDLE) :
                   state == MULT ? (cnt == CW'(ITER - 1) ? NORM : MULT) :
                   state == NORM ? DONE :
                   (bus.out_ready ? IDLE : DONE);
    end
    // Multiplicand walks left while the multiplier drains right, one digit per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {cnt, acc, mc, mp, in1_r, in2_r, k1_r, k2_r, e1_r, e2_r} <= '0;
            {s1, s2, z1, z2, f1, f2, sign_r, inf_r, zero_r} <= '0;
            mult_mant <= '0;
            total_eo  <= '0;
`ifdef POSIT_MULT_RADIX4_EN
            mc3 <= '0;
`endif
        end else if (state == IDLE && bus.in_valid) begin
            in1_r <= bus.IN1;
            in2_r <= bus.IN2;
            k1_r  <= bus.k1;
            k2_r  <= bus.k2;
            e1_r  <= bus.Exp1;
            e2_r  <= bus.Exp2;
            {s1, s2, z1, z2, f1, f2} <= {bus.Sign1, bus.Sign2, bus.zero1, bus.zero2, bus.inf1, bus.inf2};
            acc <= '0;
            mc  <= {{N{1'b0}}, bus.Mant1};
            mp  <= bus.Mant2;
            cnt <= '0;
`ifdef POSIT_MULT_RADIX4_EN
            mc3 <= {{N{1'b0}}, bus.Mant1} + {{(N-1){1'b0}}, bus.Mant1, 1'b0};
`endif
        end else if (state == MULT) begin
            acc <= acc + step;
            mc  <= mc << SH;
            mp  <= mp >> SH;
            cnt <= cnt + CW'(1);
`ifdef POSIT_MULT_RADIX4_EN
            mc3 <= mc3 << SH;
`endif
        end else if (state == NORM) begin
            mult_mant <= special ? '0 : ovf ? acc : acc << 1;
            total_eo  <= special ? '0 : eo_nx;
            sign_r    <= s1 ^ s2;
            inf_r     <= f1 | f2;
            zero_r    <= (z1 | z2) & ~(f1 | f2);
        end
    end
    assign bus.in_ready    = state == IDLE;
    assign bus.out_valid   = state == DONE;
    assign bus.IN1_o       = in1_r;
    assign bus.IN2_o       = in2_r;
    assign bus.Mult_Mant_N = mult_mant;
    assign bus.Total_EO    = total_eo;
    assign bus.Total_EON   = -total_eo;
    assign bus.E_O         = total_eo[ES-1:0];
    assign bus.sumR        = sumr;
    assign bus.R_O         = sumr[RS+2] ? -sumr : sumr + (RS+3)'(1);
    assign bus.Sign        = sign_r;
    assign bus.inf         = inf_r;
    assign bus.zero        = zero_r;
endmodule

// File: tb/tb_posit_mult_core.sv
// tb_posit_mult_core: randomized and directed checks of posit_mult_core against a behavioural model.
module tb_posit_mult_core;
    localparam int N = 32, ES = 2, RS = $clog2(N), EW = RS + ES + 2;
`ifdef POSIT_MULT_RADIX4_EN
    localparam int LAT = N / 2 + 2;
`else
    localparam int LAT = N + 2;
`endif
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;
    posit_mult_if #(.N(N), .ES(ES), .RS(RS)) bus ();
    posit_mult_core #(.N(N), .ES(ES), .RS(RS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    typedef struct {
        logic [N-1:0] in1, in2, m1, m2;
        logic s1, s2, z1, z2, i1, i2;
        logic signed [RS:0] k1, k2;
        logic [ES-1:0] e1, e2;
    } op_t;
    typedef struct {
        logic [2*N-1:0] mm;
        int teo;
        logic sign, inf, zero;
        logic [N-1:0] in1, in2;
    } exp_t;
    exp_t q[$];
    op_t cur_op;
    int tests = 0, fails = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic exp_t model(op_t o);
        exp_t e;
        logic [63:0] p;
        p = 64'(o.m1) * 64'(o.m2);
        e.inf  = o.i1 | o.i2;
        e.zero = (o.z1 | o.z2) & ~e.inf;
        e.sign = o.s1 ^ o.s2;
        e.in1  = o.in1;
        e.in2  = o.in2;
        if (o.z1 | o.z2 | o.i1 | o.i2) begin
            e.mm  = '0;
            e.teo = 0;
        end else begin
            e.mm  = p[63] ? p : p << 1;
            e.teo = int'(o.k1) * (1 << ES) + int'(o.e1) + int'(o.k2) * (1 << ES) + int'(o.e2) + int'(p[63]);
        end
        return e;
    endfunction

    task automatic compare(exp_t e);
        int sr;
        logic [EW-1:0] teon;
        sr   = e.teo >= 0 ? e.teo / (1 << ES) : -((-e.teo + (1 << ES) - 1) / (1 << ES));
        teon = EW'(-e.teo);
        chk("mant", bus.Mult_Mant_N, e.mm);
        chk("teo", bus.Total_EO, e.teo);
        chk("teon", 64'(unsigned'(bus.Total_EON)), 64'(teon));
        chk("eo", bus.E_O, e.teo - sr * (1 << ES));
        chk("sumr", bus.sumR, sr);
        chk("ro", bus.R_O, sr >= 0 ? sr + 1 : -sr);
        chk("sign", bus.Sign, e.sign);
        chk("inf", bus.inf, e.inf);
        chk("zero", bus.zero, e.zero);
        chk("in1_o", bus.IN1_o, e.in1);
        chk("in2_o", bus.IN2_o, e.in2);
    endtask

    function automatic op_t mk(logic s1, int k1, int e1, logic [N-1:0] m1, logic s2, int k2, int e2, logic [N-1:0] m2);
        op_t o;
        o.s1 = s1; o.k1 = (RS+1)'(k1); o.e1 = ES'(e1); o.m1 = m1;
        o.s2 = s2; o.k2 = (RS+1)'(k2); o.e2 = ES'(e2); o.m2 = m2;
        o.in1 = m1 ^ 32'h1234_5678;
        o.in2 = m2 ^ 32'h0F0F_0F0F;
        {o.z1, o.z2, o.i1, o.i2} = 4'b0;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        int sp;
        o = mk(1'($urandom_range(0, 1)), $urandom_range(0, 63), $urandom_range(0, 3), 32'h8000_0000 | $urandom(),
               1'($urandom_range(0, 1)), $urandom_range(0, 63), $urandom_range(0, 3), 32'h8000_0000 | $urandom());
        o.in1 = $urandom();
        o.in2 = $urandom();
        sp = $urandom_range(0, 9);
        o.z1 = sp == 0;
        o.i2 = sp == 1;
        o.z2 = sp == 2;
        o.i1 = sp == 2;
        return o;
    endfunction

    task automatic apply(op_t o);
        cur_op = o;
        bus.IN1 = o.in1; bus.IN2 = o.in2; bus.Sign1 = o.s1; bus.Sign2 = o.s2;
        bus.k1 = o.k1; bus.k2 = o.k2; bus.Exp1 = o.e1; bus.Exp2 = o.e2;
        bus.Mant1 = o.m1; bus.Mant2 = o.m2;
        bus.zero1 = o.z1; bus.zero2 = o.z2; bus.inf1 = o.i1; bus.inf2 = o.i2;
    endtask

    task automatic start(op_t o);
        int n = 0;
        @(posedge clk); #1;
        apply(o);
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) chk("accept_timeout", bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(int exp_lat, string name);
        int lat = 0;
        @(negedge clk);
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk(name, lat + 1, exp_lat);
    endtask

    task automatic consume(int d);
        repeat (d) @(posedge clk);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic chk_reset(string tag);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_in_ready"}, bus.in_ready, 1);
        chk({tag, "_mant"}, bus.Mult_Mant_N, 0);
        chk({tag, "_teo"}, bus.Total_EO, 0);
        chk({tag, "_ro"}, bus.R_O, 1);
        chk({tag, "_sign"}, bus.Sign, 0);
        chk({tag, "_in1_o"}, bus.IN1_o, 0);
    endtask

    task automatic main();
        op_t o;
        repeat (2) @(negedge clk);
        chk_reset("rst");
        @(posedge clk); #1 rst_n = 1'b1;
        start(mk(0, 0, 0, 32'h8000_0000, 0, 0, 0, 32'h8000_0000));
        wait_out(LAT, "lat_1x1");
        chk("tc1_mant", bus.Mult_Mant_N, 64'h8000_0000_0000_0000);
        chk("tc1_teo", bus.Total_EO, 0);
        chk("tc1_ro", bus.R_O, 1);
        chk("tc1_sign", bus.Sign, 0);
        consume(0);
        start(mk(0, 0, 0, 32'hC000_0000, 0, 0, 0, 32'hC000_0000));
        wait_out(LAT, "lat_15x15");
        chk("tc2_mant", bus.Mult_Mant_N, 64'h9000_0000_0000_0000);
        chk("tc2_teo", bus.Total_EO, 1);
        chk("tc2_eo", bus.E_O, 1);
        chk("tc2_sumr", bus.sumR, 0);
        chk("tc2_ro", bus.R_O, 1);
        consume(1);
        start(mk(1, -1, 3, 32'h8000_0000, 0, 0, 0, 32'h8000_0000));
        wait_out(LAT, "lat_neg");
        chk("tc3_teo", bus.Total_EO, -1);
        chk("tc3_teon", bus.Total_EON, 1);
        chk("tc3_sumr", bus.sumR, -1);
        chk("tc3_eo", bus.E_O, 3);
        chk("tc3_ro", bus.R_O, 1);
        chk("tc3_sign", bus.Sign, 1);
        consume(0);
        o = mk(0, 2, 1, 32'hA000_0000, 1, 1, 2, 32'hB000_0000);
        o.z1 = 1'b1;
        start(o);
        wait_out(2, "lat_zero");
        chk("tc4_zero", bus.zero, 1);
        chk("tc4_inf", bus.inf, 0);
        chk("tc4_mant", bus.Mult_Mant_N, 0);
        consume(0);
        o.i2 = 1'b1;
        start(o);
        wait_out(2, "lat_inf");
        chk("tc5_inf", bus.inf, 1);
        chk("tc5_zero", bus.zero, 0);
        consume(0);
        o = rand_op();
        {o.z1, o.z2, o.i1, o.i2} = 4'b0;
        start(o);
        wait_out(LAT, "lat_bp");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (i == 3) begin
                apply(mk(1, 5, 2, 32'hF000_0000, 1, 5, 2, 32'hF000_0000));
                bus.in_valid = 1'b1;
            end
            if (i == 4) bus.in_valid = 1'b0;
            @(negedge clk);
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_out_valid", bus.out_valid, 1);
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
        @(posedge clk); #1 bus.out_ready = 1'b0;
        @(negedge clk);
        chk("bp_release_in_ready", bus.in_ready, 1);
        chk("bp_release_out_valid", bus.out_valid, 0);
        @(negedge clk);
        chk("bp_no_capture", bus.out_valid, 0);
        start(mk(0, 3, 1, 32'hC000_0000, 0, 2, 2, 32'hC000_0000));
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk_reset("midrst");
        @(posedge clk); #1 rst_n = 1'b1;
        start(mk(0, 0, 0, 32'hC000_0000, 0, 0, 0, 32'hC000_0000));
        wait_out(LAT, "lat_after_rst");
        chk("tc7_mant", bus.Mult_Mant_N, 64'h9000_0000_0000_0000);
        chk("tc7_teo", bus.Total_EO, 1);
        consume(0);
        for (int i = 0; i < 40; i++) begin
            o = rand_op();
            start(o);
            wait_out((o.z1 | o.z2 | o.i1 | o.i2) ? 2 : LAT, "lat_rand");
            consume($urandom_range(0, 3));
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        apply(mk(0, 0, 0, '0, 0, 0, 0, '0));
        fork
            forever begin
                @(negedge clk);
                if (!rst_n) q.delete();
                else begin
                    if (bus.out_valid) begin
                        chk("queue_depth", 64'(q.size()), 1);
                        if (q.size() > 0) begin
                            compare(q[0]);
                            if (bus.out_ready) void'(q.pop_front());
                        end
                    end
                    if (bus.in_valid && bus.in_ready) q.push_back(model(cur_op));
                end
            end
            main();
        join_any
        disable fork;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/posit_mult_core.md
# posit_mult_core

Iterative posit multiplier datapath, one stage upstream of the posit multiplier rounding stage. Accepts two pre-extracted posit operands (sign, regime k, exponent, mantissa, zero/inf flags) through a valid/ready handshake. Forms the 2N-bit mantissa product with a multi-cycle shift-add engine, then normalises it and computes the combined scale. Holds the result (Mult_Mant_N, Total_EO, Total_EON, E_O, R_O, sumR, Sign, inf, zero) registered until the rounding stage consumes it.

## Interface
- N, 32, posit width
- ES, 2, exponent field width
- RS, $clog2(N), regime-count width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand set valid
- in_ready  out  1  core can accept operands
- IN1, IN2  in  N  raw posits, captured and forwarded unchanged
- Sign1, Sign2  in  1  operand signs
- k1, k2  in  RS+1 signed  regime values
- Exp1, Exp2  in  ES  exponent fields
- Mant1, Mant2  in  N  mantissas, hidden 1 at bit N-1
- zero1, zero2, inf1, inf2  in  1  special-value flags
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- IN1_o, IN2_o  out  N  registered copies of IN1/IN2
- Mult_Mant_N  out  2N  normalised product, hidden 1 at bit 2N-1
- Total_EO, Total_EON  out  RS+ES+2  combined scale and its two's-complement negation
- E_O  out  ES  Total_EO[ES-1:0]
- sumR  out  RS+3 signed  Total_EO >>> ES
- R_O  out  RS+3 signed  regime run length
- Sign, inf, zero  out  1  result sign and special flags

## Operation
- FSM: IDLE, MULT, NORM, DONE.
- IDLE: in_ready=1. On in_valid, capture all inputs.
  - If any special flag is set, go to NORM.
  - Otherwise clear the accumulator, load multiplicand Mant1 and the 3*Mant1 partial, load multiplier Mant2, clear the iteration counter, and go to MULT.
- MULT: radix-4 iteration each cycle.
  - acc += digit*Mant1 shifted to digit position, where digit = next 2 multiplier bits (0, 1, 2 or 3; 3 uses the precomputed partial).
  - N/2 iterations, then go to NORM.
- NORM:
  - ovf = prod[2N-1]. Mult_Mant_N = ovf ? prod : prod<<1.
  - Total_EO = (k1<<ES)+Exp1 + (k2<<ES)+Exp2 + ovf, signed, RS+ES+2 bits (no overflow possible).
  - sumR = Total_EO >>> ES.
  - R_O = sumR>=0 ? sumR+1 : -sumR.
  - Sign = Sign1^Sign2. inf = inf1|inf2. zero = (zero1|zero2)&~inf.
  - On a special path, Mult_Mant_N=0, Total_EO=0, sumR=0, R_O=1, E_O=0.
  - Go to DONE.
- DONE: out_valid=1, all outputs stable. On out_ready, go to IDLE.
- in_ready=0 in MULT/NORM/DONE; no new operand is accepted before the result is consumed.
- Reset (any state): FSM goes to IDLE. out_valid=0, in_ready=1, every data output =0 except R_O=1. Any in-flight operation is discarded.

## Timing
- Acceptance edge = cycle 0.
- Normal operand: out_valid rises at cycle N/2+2 (18 for N=32).
- Special operand: out_valid rises at cycle 2.
- out_valid and data stay stable while out_ready=0.
- The consumption edge returns the FSM to IDLE; in_ready=1 the next cycle, so minimum initiation interval = latency+1.
- out_ready while out_valid=0 is ignored.
- in_valid while in_ready=0 is ignored; the source holds operands.

## Configuration
- POSIT_MULT_RADIX4_EN defined: radix-4 engine, N/2 MULT cycles, 3*Mant1 partial register present.
- Undefined: radix-2 engine, one multiplier bit per cycle, N MULT cycles, normal-path latency N+2.
- Results are bit-identical in both modes.

## Test plan
- 1.0*1.0 (k=0, Exp=0, Mant=0x80000000 both) -> Mult_Mant_N=0x8000_0000_0000_0000, Total_EO=0, sumR=0, R_O=1, E_O=0, Sign=0; out_valid at cycle 18 (34 without macro).
- 1.5*1.5 (Mant=0xC0000000, k=0, Exp=0) -> Mult_Mant_N=0x9000_0000_0000_0000, Total_EO=1, E_O=1, sumR=0, R_O=1.
- (k1=-1, Exp1=3, Mant1=0x80000000, Sign1=1) * (k2=0, Exp2=0, Mant2=0x80000000) -> Total_EO=-1, Total_EON=1, sumR=-1, E_O=3, R_O=1, Sign=1.
- zero1=1 -> zero=1, inf=0, Mult_Mant_N=0, out_valid at cycle 2. inf2=1 with zero1=1 -> inf=1, zero=0.
- Back-pressure: out_ready=0 for 10 cycles after out_valid.
  - Outputs stay constant, in_ready=0, a pulsed in_valid is not captured.
  - Then out_ready=1 -> in_ready=1 the next cycle.
- rst_n low at cycle 5 of MULT -> out_valid=0, in_ready=1, outputs reset values; a following 1.5*1.5 produces the correct result with full latency.
